water_light_driver: RTL



---
 rtl/water_light_pkg.sv | 49 ++++
 rtl/water_light_prescaler.sv | 32 +++
 rtl/water_light_driver.sv | 93 +++++++++
 3 files changed

// File: rtl/water_light_pkg.sv
// Shared encodings for the WaterLight LED driver: mode bytes, FSM states and
// the initial LED pattern of each state.
package water_light_pkg;

  localparam logic [7:0] MODE_LEFT   = 8'h01;
  localparam logic [7:0] MODE_RIGHT  = 8'h02;
  localparam logic [7:0] MODE_FLASH  = 8'h03;
  localparam logic [7:0] MODE_BOUNCE = 8'h04;

  localparam logic [7:0] INIT_IDLE   = 8'h00;
  localparam logic [7:0] INIT_LEFT   = 8'h01;
  localparam logic [7:0] INIT_RIGHT  = 8'h80;
  localparam logic [7:0] INIT_FLASH  = 8'hFF;
  localparam logic [7:0] INIT_BOUNCE = 8'h01;

  typedef enum logic [2:0] {
    StIdle,
    StLeft,
    StRight,
    StFlash,
    StBounce
  } state_e;

  typedef enum logic {
    DirLeft,
    DirRight
  } dir_e;

  function automatic state_e decode_mode(input logic [7:0] mode);
    case (mode)
      MODE_LEFT:   return StLeft;
      MODE_RIGHT:  return StRight;
      MODE_FLASH:  return StFlash;
      MODE_BOUNCE: return StBounce;
      default:     return StIdle;
    endcase
  endfunction

  function automatic logic [7:0] init_pattern(input state_e st);
    case (st)
      StLeft:   return INIT_LEFT;
      StRight:  return INIT_RIGHT;
      StFlash:  return INIT_FLASH;
      StBounce: return INIT_BOUNCE;
      default:  return INIT_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/water_light_prescaler.sv
// Programmable step prescaler: tick once every `speed` cycles, idle when speed is 0.
module water_light_prescaler #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [CNT_W-1:0] speed,
  input  logic             clr,
  output logic             tick
);

  logic [CNT_W-1:0] count_q, count_d;

  // >= rather than == so a shrinking speed still produces a step next cycle.
  assign tick = (speed != '0) && (count_q >= (speed - CNT_W'(1)));

  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (clr || (speed == '0) || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/water_light_driver.sv
// LED bank animator driven by the WaterLight register slave's mode and speed words.
module water_light_driver
  import water_light_pkg::*;
#(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned LED_W = 8
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [7:0]       WaterLight_mode,
  input  logic [CNT_W-1:0] WaterLight_speed,
  output logic [LED_W-1:0] LED,
  output logic             LED_tick
);

  logic [7:0]       mode_q;
  state_e           state_q, state_d;
  dir_e             dir_q, dir_d;
  logic [LED_W-1:0] led_q, led_step;
  logic             tick_q;
  logic             mode_chg;
  logic             tick;

  assign mode_chg = (WaterLight_mode != mode_q);
  assign state_d  = decode_mode(WaterLight_mode);

  water_light_prescaler #(
    .CNT_W (CNT_W)
  ) u_prescaler (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .speed  (WaterLight_speed),
    .clr    (mode_chg),
    .tick   (tick)
  );

  always_comb begin
    led_step = led_q;
    dir_d    = dir_q;
    unique case (state_q)
      StLeft:  led_step = {led_q[LED_W-2:0], led_q[LED_W-1]};
      StRight: led_step = {led_q[0], led_q[LED_W-1:1]};
      StFlash: led_step = ~led_q;
      StBounce: begin
        if (dir_q == DirLeft) begin
          if (led_q == LED_W'(8'h80)) begin
            led_step = LED_W'(8'h40);
            dir_d    = DirRight;
          end else begin
            led_step = led_q << 1;
          end
        end else begin
          if (led_q == LED_W'(8'h01)) begin
            led_step = LED_W'(8'h02);
            dir_d    = DirLeft;
          end else begin
            led_step = led_q >> 1;
          end
        end
      end
      default: led_step = '0;
    endcase
  end

  // A mode change outranks a coincident tick: reload, no step pulse.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      mode_q  <= 8'h00;
      state_q <= StIdle;
      dir_q   <= DirLeft;
      led_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      mode_q <= WaterLight_mode;
      if (mode_chg) begin
        state_q <= state_d;
        led_q   <= LED_W'(init_pattern(state_d));
        dir_q   <= DirLeft;
        tick_q  <= 1'b0;
      end else if (tick) begin
        led_q  <= led_step;
        dir_q  <= dir_d;
        tick_q <= 1'b1;
      end else begin
        tick_q <= 1'b0;
      end
    end
  end

  assign LED      = led_q;
  assign LED_tick = tick_q;

endmodule
